// File: rtl/mem_port_arb.sv
// Shares one single-port SRAM between instruction fetch and load/store, data first.
// Define MEM_ARB_STARVE_GUARD_EN to build the fetch starvation guard (STARVE_MAX denials).
module mem_port_arb #(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        inst_sram_en,
    input  logic [3:0]  inst_sram_we,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic        inst_stall,
    output logic [31:0] inst_rdata,
    output logic        inst_rdata_valid,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_we,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic        data_stall,
    output logic [31:0] data_rdata,
    output logic        data_rdata_valid,
    output logic        sram_en,
    output logic [3:0]  sram_we,
    output logic [31:0] sram_addr,
    output logic [31:0] sram_wdata,
    input  logic [31:0] sram_rdata
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_INST = 2'd1,
        OWN_DATA = 2'd2
    } owner_t;

    owner_t owner_q;
    owner_t owner_d;
    logic   grant_i;
    logic   grant_d;
    logic   force_inst;

    if (STARVE_MAX < 1 || STARVE_MAX > 7) begin : g_bad_starve_max
        $error("mem_port_arb: STARVE_MAX must be in 1..7");
    end

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

    logic [2:0] starve_cnt;

    // Counts back-to-back fetch denials; any fetch grant or idle fetch restarts it.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= 3'd0;
        end else if (grant_i || !inst_sram_en) begin
            starve_cnt <= 3'd0;
        end else if (grant_d && starve_cnt != STARVE_LIM) begin
            starve_cnt <= starve_cnt + 3'd1;
        end
    end

    assign force_inst = inst_sram_en && (starve_cnt == STARVE_LIM);
`else
    assign force_inst = 1'b0;
`endif

    assign grant_d    = data_sram_en && !force_inst;
    assign grant_i    = inst_sram_en && !grant_d;
    assign inst_stall = inst_sram_en && !grant_i;
    assign data_stall = data_sram_en && !grant_d;

    always_comb begin
        sram_en    = 1'b0;
        sram_we    = 4'd0;
        sram_addr  = 32'd0;
        sram_wdata = 32'd0;
        owner_d    = OWN_NONE;
        if (grant_d) begin
            sram_en    = data_sram_en;
            sram_we    = data_sram_we;
            sram_addr  = data_sram_addr;
            sram_wdata = data_sram_wdata;
            if (data_sram_we == 4'd0) begin
                owner_d = OWN_DATA;
            end
        end else if (grant_i) begin
            sram_en    = inst_sram_en;
            sram_we    = inst_sram_we;
            sram_addr  = inst_sram_addr;
            sram_wdata = inst_sram_wdata;
            if (inst_sram_we == 4'd0) begin
                owner_d = OWN_INST;
            end
        end
    end

    // Remembers who issued last cycle's read so the returning word is steered to it.
    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q <= OWN_NONE;
        end else begin
            owner_q <= owner_d;
        end
    end

    // Reset also masks a response already in flight so it never surfaces.
    assign inst_rdata_valid = (owner_q == OWN_INST) && !flush && !reset;
    assign data_rdata_valid = (owner_q == OWN_DATA) && !reset;
    assign inst_rdata       = sram_rdata;
    assign data_rdata       = sram_rdata;

endmodule
